// File: rtl/crc_framer_pkg.sv
// Shared types and CRC-16/X.25 defaults for the serial CRC framer.
package crc_framer_pkg;

  typedef enum logic [1:0] {IDLE, DATA, FCS} state_e;

  localparam logic [15:0] CRC16_X25_POLY    = 16'h8408;
  localparam logic [15:0] CRC16_X25_INIT    = 16'hFFFF;
  localparam logic [15:0] CRC16_X25_RESIDUE = 16'hF0B8;

endpackage

// File: rtl/crc_framer_if.sv
// Serial transmit bus between a bit source/sink and the framer.
// fcs_ok only exists when CRC_FRAMER_CHECK_EN is defined.
interface crc_framer_if;

  logic tx_data;
  logic tx_data_valid;
  logic tx_ready;
  logic tx_out;
  logic tx_out_valid;
  logic tx_out_fcs;
  logic frame_err;

`ifdef CRC_FRAMER_CHECK_EN
  logic fcs_ok;

  modport slave (
    input  tx_data, tx_data_valid,
    output tx_ready, tx_out, tx_out_valid, tx_out_fcs, frame_err, fcs_ok
  );
  modport master (
    output tx_data, tx_data_valid,
    input  tx_ready, tx_out, tx_out_valid, tx_out_fcs, frame_err, fcs_ok
  );
`else
  modport slave (
    input  tx_data, tx_data_valid,
    output tx_ready, tx_out, tx_out_valid, tx_out_fcs, frame_err
  );
  modport master (
    output tx_data, tx_data_valid,
    input  tx_ready, tx_out, tx_out_valid, tx_out_fcs, frame_err
  );
`endif

endinterface

// File: rtl/crc_framer_crc_lfsr.sv
// Reflected serial CRC register: load reseeds INIT (and may combine with step),
// step folds one data bit in, shift moves the register right to emit FCS bits.
module crc_lfsr #(
  parameter int             W    = 16,
  parameter logic [W-1:0]   POLY = '0,
  parameter logic [W-1:0]   INIT = '1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic         step_i,
  input  logic         shift_i,
  input  logic         d_i,
  output logic         lsb_o,
  output logic [W-1:0] crc_o
);

  logic [W-1:0] crc_q, crc_d, base;

  always_comb begin
    base  = load_i ? INIT : crc_q;
    crc_d = base;
    if (step_i) begin
      crc_d = (base >> 1) ^ ((base[0] ^ d_i) ? POLY : '0);
    end else if (shift_i) begin
      crc_d = base >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) crc_q <= INIT;
    else          crc_q <= crc_d;
  end

  assign lsb_o = crc_q[0];
  assign crc_o = crc_q;

endmodule

// File: rtl/crc_framer.sv
// Serial CRC framer: data bits pass through, complemented FCS follows with no gap, length policed.
// CRC_FRAMER_CHECK_EN adds a loopback checker over tx_out that drives fcs_ok.
module crc_framer
  import crc_framer_pkg::*;
#(
  parameter int               CRC_W   = 16,
  parameter logic [CRC_W-1:0] POLY    = CRC16_X25_POLY,
  parameter logic [CRC_W-1:0] INIT    = CRC16_X25_INIT,
  parameter logic [CRC_W-1:0] XOROUT  = 16'hFFFF,
  parameter int               MIN_LEN = 8,
  parameter int               MAX_LEN = 80,
  parameter logic [CRC_W-1:0] RESIDUE = CRC16_X25_RESIDUE
) (
  input  logic         clk,
  input  logic         reset_n,
  crc_framer_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam int FCS_W = $clog2(CRC_W);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_LEN);
  localparam logic [FCS_W-1:0] FCS_LAST = FCS_W'(CRC_W - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [FCS_W-1:0] fcs_cnt_q, fcs_cnt_d;
  logic             out_q, out_d, vld_q, vld_d, fcs_q, fcs_d, err_q, err_d;
  logic             crc_load, crc_step, crc_shift, crc_lsb;
  logic [CRC_W-1:0] gen_crc_unused;

  assign cnt_inc = cnt_q + 1'b1;

  crc_lfsr #(.W(CRC_W), .POLY(POLY), .INIT(INIT)) u_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (crc_load),
    .step_i  (crc_step),
    .shift_i (crc_shift),
    .d_i     (bus.tx_data),
    .lsb_o   (crc_lsb),
    .crc_o   (gen_crc_unused)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      fcs_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fcs_cnt_q <= fcs_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fcs_cnt_d = fcs_cnt_q;
    case (state_q)
      IDLE: if (bus.tx_data_valid) begin
        cnt_d     = CNT_W'(1);
        fcs_cnt_d = '0;
        state_d   = (MAX_LEN == 1) ? FCS : DATA;
      end
      DATA: if (bus.tx_data_valid) begin
        cnt_d = cnt_inc;
        if (cnt_inc == MAX_C) begin
          state_d   = FCS;
          fcs_cnt_d = '0;
        end
      end else if (cnt_q >= MIN_C) begin
        // FCS bit 0 goes out in this same cycle, so FCS state resumes at bit 1
        state_d   = FCS;
        fcs_cnt_d = FCS_W'(1);
        cnt_d     = '0;
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      FCS: begin
        fcs_cnt_d = fcs_cnt_q + 1'b1;
        if (fcs_cnt_q == FCS_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          fcs_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CRC_FRAMER_CHECK_EN
  logic first_q, first_d, last_q, last_d, done_q, chk_lsb_unused;
  logic [CRC_W-1:0] chk_crc;
`endif

  always_comb begin
    out_d     = 1'b0;
    vld_d     = 1'b0;
    fcs_d     = 1'b0;
    err_d     = 1'b0;
    crc_load  = 1'b0;
    crc_step  = 1'b0;
    crc_shift = 1'b0;
`ifdef CRC_FRAMER_CHECK_EN
    first_d   = 1'b0;
    last_d    = 1'b0;
`endif
    case (state_q)
      IDLE: if (bus.tx_data_valid) begin
        crc_load = 1'b1;
        crc_step = 1'b1;
        out_d    = bus.tx_data;
        vld_d    = 1'b1;
`ifdef CRC_FRAMER_CHECK_EN
        first_d  = 1'b1;
`endif
      end
      DATA: if (bus.tx_data_valid) begin
        crc_step = 1'b1;
        out_d    = bus.tx_data;
        vld_d    = 1'b1;
      end else if (cnt_q >= MIN_C) begin
        crc_shift = 1'b1;
        out_d     = crc_lsb ^ XOROUT[0];
        vld_d     = 1'b1;
        fcs_d     = 1'b1;
      end else begin
        err_d = 1'b1;
      end
      FCS: begin
        crc_shift = 1'b1;
        out_d     = crc_lsb ^ XOROUT[fcs_cnt_q];
        vld_d     = 1'b1;
        fcs_d     = 1'b1;
`ifdef CRC_FRAMER_CHECK_EN
        last_d    = (fcs_cnt_q == FCS_LAST);
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_q <= 1'b0;
      vld_q <= 1'b0;
      fcs_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      out_q <= out_d;
      vld_q <= vld_d;
      fcs_q <= fcs_d;
      err_q <= err_d;
    end
  end

  assign bus.tx_ready     = reset_n && (state_q != FCS);
  assign bus.tx_out       = out_q;
  assign bus.tx_out_valid = vld_q;
  assign bus.tx_out_fcs   = fcs_q;
  assign bus.frame_err    = err_q;

`ifdef CRC_FRAMER_CHECK_EN
  // Runs over the registered output stream so it sees exactly what leaves the block
  crc_lfsr #(.W(CRC_W), .POLY(POLY), .INIT(INIT)) u_chk (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (first_q),
    .step_i  (vld_q),
    .shift_i (1'b0),
    .d_i     (out_q),
    .lsb_o   (chk_lsb_unused),
    .crc_o   (chk_crc)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      first_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      first_q <= first_d;
      last_q  <= last_d;
      done_q  <= last_q;
    end
  end

  assign bus.fcs_ok = done_q && (chk_crc == RESIDUE);
`endif

endmodule
